// File: rtl/display_pkg.sv
// Shared VGA 640x480@60 timing constants, glyph geometry and the glyph bit-index helper.
package display_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned CNT_W      = 10;
  localparam int unsigned GLYPH_W    = 3;
  localparam int unsigned GLYPH_H    = 5;
  localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int unsigned BOX_COLS   = 7;

  typedef struct packed {
    logic pixel;
    logic de;
    logic hsync_n;
    logic vsync_n;
  } scan_t;

  localparam scan_t SCAN_RST = '{pixel: 1'b0, de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

  // Row-major, MSB = top-left: bit = 14 - (3*cy + gx).
  function automatic logic [3:0] glyph_bit_idx(input logic [2:0] cy, input logic [2:0] gx);
    logic [4:0] lin;
    lin = 5'(cy) * 5'd3 + 5'(gx);
    return 4'(5'd14 - lin);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters with sync/active decode and frame-position strobes, gated by pix_en.
module vga_timing
  import display_pkg::*;
#(
  parameter int unsigned HActive = H_ACTIVE,
  parameter int unsigned HFp     = H_FP,
  parameter int unsigned HSync   = H_SYNC,
  parameter int unsigned HBp     = H_BP,
  parameter int unsigned VActive = V_ACTIVE,
  parameter int unsigned VFp     = V_FP,
  parameter int unsigned VSync   = V_SYNC,
  parameter int unsigned VBp     = V_BP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_en_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             active_o,
  output logic             hsync_n_o,
  output logic             vsync_n_o,
  output logic             line_end_o,
  output logic             frame_origin_o,
  output logic             shadow_load_o
);

  localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal = VActive + VFp + VSync + VBp;

  if (HTotal > (1 << CNT_W) || VTotal > (1 << CNT_W)) begin : g_bad_total
    $error("vga_timing: line or frame length exceeds counter width");
  end

  localparam logic [CNT_W-1:0] HLast      = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast      = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HAct       = CNT_W'(HActive);
  localparam logic [CNT_W-1:0] VAct       = CNT_W'(VActive);
  localparam logic [CNT_W-1:0] HSyncStart = CNT_W'(HActive + HFp);
  localparam logic [CNT_W-1:0] HSyncEnd   = CNT_W'(HActive + HFp + HSync);
  localparam logic [CNT_W-1:0] VSyncStart = CNT_W'(VActive + VFp);
  localparam logic [CNT_W-1:0] VSyncEnd   = CNT_W'(VActive + VFp + VSync);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_i) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o            = h_q;
  assign v_o            = v_q;
  assign active_o       = (h_q < HAct) && (v_q < VAct);
  assign hsync_n_o      = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
  assign vsync_n_o      = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
  assign line_end_o     = pix_en_i && (h_q == HLast);
  assign frame_origin_o = pix_en_i && (h_q == '0) && (v_q == '0);
  assign shadow_load_o  = pix_en_i && (h_q == '0) && (v_q == VAct);

endmodule

// File: rtl/glyph_scanout.sv
// Scans a two-glyph 3x5 bitmap out as a 1-bit VGA stream with a frame-coherent shadow copy.
// Optional outline around the text box when GLYPH_SCANOUT_BORDER_EN is defined.
module glyph_scanout
  import display_pkg::*;
#(
  parameter int unsigned HActive = H_ACTIVE,
  parameter int unsigned HFp     = H_FP,
  parameter int unsigned HSync   = H_SYNC,
  parameter int unsigned HBp     = H_BP,
  parameter int unsigned VActive = V_ACTIVE,
  parameter int unsigned VFp     = V_FP,
  parameter int unsigned VSync   = V_SYNC,
  parameter int unsigned VBp     = V_BP,
  parameter int unsigned Scale   = 16,
  parameter int unsigned X0      = 264,
  parameter int unsigned Y0      = 200
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pix_en_i,
  input  logic [2*GLYPH_BITS-1:0] framebuffer_i,
  output logic                    pixel_o,
  output logic                    de_o,
  output logic                    hsync_o,
  output logic                    vsync_o,
  output logic                    frame_start_o
);

  if (X0 < 1 || Y0 < 1 || Scale < 1) begin : g_bad_origin
    $error("glyph_scanout: X0, Y0 and Scale must be at least 1");
  end
  if (X0 + BOX_COLS * Scale > HActive) begin : g_bad_x
    $error("glyph_scanout: text box exceeds active width");
  end
  if (Y0 + GLYPH_H * Scale > VActive) begin : g_bad_y
    $error("glyph_scanout: text box exceeds active height");
  end

  localparam int unsigned      SubW      = (Scale > 1) ? $clog2(Scale) : 1;
  localparam logic [SubW-1:0]  ScaleLast = SubW'(Scale - 1);
  localparam logic [CNT_W-1:0] XSeed     = CNT_W'(X0 - 1);
  localparam logic [CNT_W-1:0] YSeed     = CNT_W'(Y0 - 1);

  logic [CNT_W-1:0] h, v;
  logic active, hsync_n, vsync_n, line_end, frame_origin, shadow_load;

  vga_timing #(
    .HActive(HActive), .HFp(HFp), .HSync(HSync), .HBp(HBp),
    .VActive(VActive), .VFp(VFp), .VSync(VSync), .VBp(VBp)
  ) u_timing (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pix_en_i      (pix_en_i),
    .h_o           (h),
    .v_o           (v),
    .active_o      (active),
    .hsync_n_o     (hsync_n),
    .vsync_n_o     (vsync_n),
    .line_end_o    (line_end),
    .frame_origin_o(frame_origin),
    .shadow_load_o (shadow_load)
  );

  logic [2*GLYPH_BITS-1:0] shadow_q, shadow_d;
  logic                    in_x_q, in_x_d, in_y_q, in_y_d;
  logic [2:0]              cx_q, cx_d, cy_q, cy_d;
  logic [SubW-1:0]         sx_q, sx_d, sy_q, sy_d;

  // Cell trackers are seeded one position early so they line up with h/v on entry to the box.
  always_comb begin
    shadow_d = shadow_load ? framebuffer_i : shadow_q;
    in_x_d   = in_x_q;
    cx_d     = cx_q;
    sx_d     = sx_q;
    in_y_d   = in_y_q;
    cy_d     = cy_q;
    sy_d     = sy_q;
    if (pix_en_i) begin
      if (h == XSeed) begin
        in_x_d = 1'b1;
        cx_d   = '0;
        sx_d   = '0;
      end else if (in_x_q) begin
        if (sx_q == ScaleLast) begin
          sx_d = '0;
          if (cx_q == 3'(BOX_COLS - 1)) in_x_d = 1'b0;
          else                          cx_d   = cx_q + 1'b1;
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
    end
    if (line_end) begin
      if (v == YSeed) begin
        in_y_d = 1'b1;
        cy_d   = '0;
        sy_d   = '0;
      end else if (in_y_q) begin
        if (sy_q == ScaleLast) begin
          sy_d = '0;
          if (cy_q == 3'(GLYPH_H - 1)) in_y_d = 1'b0;
          else                         cy_d   = cy_q + 1'b1;
        end else begin
          sy_d = sy_q + 1'b1;
        end
      end
    end
  end

  logic [GLYPH_BITS-1:0] left_glyph, right_glyph;
  logic [2:0]            gx;
  logic [3:0]            bit_idx;
  logic                  glyph_bit;
  logic                  border;

  assign left_glyph  = shadow_q[2*GLYPH_BITS-1:GLYPH_BITS];
  assign right_glyph = shadow_q[GLYPH_BITS-1:0];

  always_comb begin
    gx        = '0;
    glyph_bit = 1'b0;
    if (cx_q < 3'(GLYPH_W))      gx = cx_q;
    else if (cx_q > 3'(GLYPH_W)) gx = cx_q - 3'(GLYPH_W + 1);
    bit_idx = glyph_bit_idx(cy_q, gx);
    if (cx_q < 3'(GLYPH_W))      glyph_bit = left_glyph[bit_idx];
    else if (cx_q > 3'(GLYPH_W)) glyph_bit = right_glyph[bit_idx];
  end

`ifdef GLYPH_SCANOUT_BORDER_EN
  localparam logic [CNT_W-1:0] BxL = CNT_W'(X0 - 1);
  localparam logic [CNT_W-1:0] BxR = CNT_W'(X0 + BOX_COLS * Scale);
  localparam logic [CNT_W-1:0] ByT = CNT_W'(Y0 - 1);
  localparam logic [CNT_W-1:0] ByB = CNT_W'(Y0 + GLYPH_H * Scale);

  assign border = (((h == BxL) || (h == BxR)) && (v >= ByT) && (v <= ByB)) ||
                  (((v == ByT) || (v == ByB)) && (h >= BxL) && (h <= BxR));
`else
  assign border = 1'b0;
`endif

  // Two-stage output pipeline; syncs share the pixel delay so all outputs stay aligned.
  scan_t s1_q, s1_d, s2_q, s2_d;
  logic  fs1_q, fs1_d, fs_q, fs_d;

  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    fs1_d = fs1_q;
    if (pix_en_i) begin
      s1_d.pixel   = active && ((in_x_q && in_y_q && glyph_bit) || border);
      s1_d.de      = active;
      s1_d.hsync_n = hsync_n;
      s1_d.vsync_n = vsync_n;
      fs1_d        = frame_origin;
      s2_d         = s1_q;
    end
    // Single-clock pulse even when the following cycles are disabled.
    fs_d = pix_en_i && fs1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      in_x_q   <= 1'b0;
      cx_q     <= '0;
      sx_q     <= '0;
      in_y_q   <= 1'b0;
      cy_q     <= '0;
      sy_q     <= '0;
      s1_q     <= SCAN_RST;
      s2_q     <= SCAN_RST;
      fs1_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      in_x_q   <= in_x_d;
      cx_q     <= cx_d;
      sx_q     <= sx_d;
      in_y_q   <= in_y_d;
      cy_q     <= cy_d;
      sy_q     <= sy_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      fs1_q    <= fs1_d;
      fs_q     <= fs_d;
    end
  end

  assign pixel_o       = s2_q.pixel;
  assign de_o          = s2_q.de;
  assign hsync_o       = s2_q.hsync_n;
  assign vsync_o       = s2_q.vsync_n;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_glyph_scanout.sv
// Self-checking bench for glyph_scanout on a reduced raster so several frames fit in a short run.
module tb_glyph_scanout;

  localparam int HA = 40, HF = 2, HS = 4, HB = 2;
  localparam int VA = 24, VF = 2, VS = 2, VB = 2;
  localparam int S = 2, X0 = 5, Y0 = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [29:0] F1 = {15'b111101101101111, 15'b001001001001001};
  localparam logic [29:0] F2 = ~F1;
`ifdef GLYPH_SCANOUT_BORDER_EN
  localparam logic BORD = 1'b1;
`else
  localparam logic BORD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, pix_en;
  logic [29:0] fb;
  logic pixel, de, hsync, vsync, frame_start;

  glyph_scanout #(
    .HActive(HA), .HFp(HF), .HSync(HS), .HBp(HB),
    .VActive(VA), .VFp(VF), .VSync(VS), .VBp(VB),
    .Scale(S), .X0(X0), .Y0(Y0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pix_en_i     (pix_en),
    .framebuffer_i(fb),
    .pixel_o      (pixel),
    .de_o         (de),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic pix; logic de; logic hs; logic vs; logic fs;} out_t;
  typedef struct {int h; int v; out_t exp;} sb_t;
  typedef struct {int h; int v; logic exp;} probe_t;

  localparam out_t RST_OUT = '{pix: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  sb_t  sbq[$];
  int   checks = 0, failures = 0;
  int   mh, mv;
  logic [29:0] msh;
  out_t last_exp;
  logic seen [VT][HT];
  int   t_hs, t_de, t_vs, t_fs;
  probe_t probes [13];

  function automatic out_t model(input int h, input int v, input logic [29:0] sh);
    out_t o;
    int cx, cy, idx;
    logic bit_v;
    o.de = (h < HA) && (v < VA);
    o.hs = !(h >= HA + HF && h < HA + HF + HS);
    o.vs = !(v >= VA + VF && v < VA + VF + VS);
    o.fs = (h == 0) && (v == 0);
    bit_v = 1'b0;
    if (h >= X0 && h < X0 + 7 * S && v >= Y0 && v < Y0 + 5 * S) begin
      cx = (h - X0) / S;
      cy = (v - Y0) / S;
      if (cx < 3) begin
        idx = 14 - (3 * cy + cx);
        bit_v = sh[15 + idx];
      end else if (cx > 3) begin
        idx = 14 - (3 * cy + cx - 4);
        bit_v = sh[idx];
      end
    end
    if (BORD && ((((h == X0 - 1) || (h == X0 + 7 * S)) && v >= Y0 - 1 && v <= Y0 + 5 * S) ||
                 (((v == Y0 - 1) || (v == Y0 + 5 * S)) && h >= X0 - 1 && h <= X0 + 7 * S)))
      bit_v = 1'b1;
    o.pix = o.de && bit_v;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic en);
    out_t act, held;
    sb_t  e;
    pix_en = en;
    if (en) begin
      e.h = mh;
      e.v = mv;
      e.exp = model(mh, mv, msh);
      sbq.push_back(e);
      if (mh == 0 && mv == VA) msh = fb;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    @(posedge clk);
    #1;
    act = {pixel, de, hsync, vsync, frame_start};
    if (en) begin
      if (sbq.size() >= 2) begin
        e = sbq.pop_front();
        check($sformatf("out@h%0d,v%0d", e.h, e.v), act, e.exp);
        last_exp = e.exp;
        seen[e.v][e.h] = pixel;
        if (!hsync) t_hs++;
        if (de) t_de++;
        if (!vsync) t_vs++;
      end else begin
        check("out_after_reset", act, RST_OUT);
      end
    end else begin
      held = last_exp;
      held.fs = 1'b0;
      check("hold_when_disabled", act, held);
    end
    if (frame_start) t_fs++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic clear_tallies();
    t_hs = 0; t_de = 0; t_vs = 0; t_fs = 0;
  endtask

  initial begin
    probes = '{
      '{X0,             Y0,             1'b1},  // left row0 col0
      '{X0 + S,         Y0,             1'b1},  // left row0 middle
      '{X0 + S,         Y0 + S,         1'b0},  // left row1 middle
      '{X0 + 4 * S,     Y0,             1'b0},  // right cell4 row0
      '{X0 + 6 * S,     Y0,             1'b1},  // right cell6 row0
      '{X0 + 3 * S,     Y0,             1'b0},  // gap column
      '{X0,             Y0 + 2 * S,     1'b1},  // left row2 col0
      '{X0 + 2 * S + 1, Y0 + 5 * S - 1, 1'b1},  // left bottom-right
      '{X0 + 7 * S - 1, Y0 + 5 * S - 1, 1'b1},  // right bottom-right
      '{X0 - 1,         Y0,             BORD},  // left outline
      '{X0 + 7 * S,     Y0,             BORD},  // right outline
      '{X0,             Y0 + 5 * S,     BORD},  // bottom outline
      '{X0 - 1,         Y0 - 1,         BORD}   // corner
    };

    rst_n = 1'b0; pix_en = 1'b1; fb = '0;
    mh = 0; mv = 0; msh = '0; last_exp = RST_OUT;
    clear_tallies();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {pixel, de, hsync, vsync, frame_start}, RST_OUT);
    rst_n = 1'b1;
    fb = F1;

    // Frame 0: first frame_start two enabled cycles after h=v=0, blank shadow.
    step(1'b1);
    check("fs_not_yet", frame_start, 1'b0);
    step(1'b1);
    check("fs_first", frame_start, 1'b1);
    run(FRAME - 2);
    check("blank_shadow_f0", seen[Y0][X0], 1'b0);

    // Frame 1: F1 visible; whole-frame tallies.
    clear_tallies();
    run(FRAME);
    check("hsync_low_count", t_hs, HS * VT);
    check("de_count", t_de, HA * VA);
    check("vsync_low_count", t_vs, VS * HT);
    check("fs_count_f1", t_fs, 1);
    for (int i = 0; i < 13; i++)
      check($sformatf("probe%0d(%0d,%0d)", i, probes[i].h, probes[i].v),
            seen[probes[i].v][probes[i].h], probes[i].exp);

    // Frame 2: framebuffer changes during active video, before the box.
    run(2 * HT);
    fb = F2;
    run(FRAME - 2 * HT);
    check("f2_keeps_old_a", seen[Y0][X0], 1'b1);
    check("f2_keeps_old_b", seen[Y0 + S][X0 + S], 1'b0);
    run(FRAME);
    check("f3_new_a", seen[Y0][X0], 1'b0);
    check("f3_new_b", seen[Y0 + S][X0 + S], 1'b1);

    // 50% pix_en duty for one frame of enabled cycles.
    clear_tallies();
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1);
      step(1'b0);
    end
    check("fs_count_toggle", t_fs, 1);

    // Reset asserted mid-frame on line 12.
    for (int i = 0; i < FRAME && !(mv == 12 && mh == 10); i++) step(1'b1);
    check("reached_line12", mv, 12);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {pixel, de, hsync, vsync, frame_start}, RST_OUT);
    mh = 0; mv = 0; msh = '0; last_exp = RST_OUT;
    sbq.delete();
    @(posedge clk);
    #1;
    check("reset_held", {pixel, de, hsync, vsync, frame_start}, RST_OUT);
    rst_n = 1'b1;
    run(FRAME);
    check("shadow_cleared", seen[Y0 + S][X0 + S], 1'b0);
    check("border_after_reset", seen[Y0 - 1][X0 - 1], BORD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
